ipml_fifo_rr_arbiter_v1_0: RTL

Round-robin read scheduler that drains N prefetch FIFO read ports (rd_data/rd_vld/rd_en first-word-fall-through style) into a single registered valid/ready stream. It sits on the read-clock side of the HSST lane FIFOs. It owns every FIFO rd_en, holds a grant for a whole packet (or a bounded burst), and tags each output beat with its source port.

---
 rtl/ipml_fifo_rr_arbiter_v1_0.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/ipml_fifo_rr_arbiter_v1_0.sv
// ---------------------------------------------------------------------------
// ipml_fifo_rr_arbiter_v1_0
//
// Round-robin read scheduler draining N_PORT first-word-fall-through FIFO
// read ports into one registered valid/ready stream. A grant is held for a
// whole packet (PKT_MODE=1) or for up to MAX_BURST beats / until the source
// runs empty (PKT_MODE=0). Every output beat is tagged with its source port.
//
// Ports
//   clk        FIFO read clock
//   rst_n      asynchronous active-low reset
//   in_data    FIFO rd_data, port i at [i*W +: W]
//   in_vld     FIFO rd_vld per port
//   in_last    end-of-packet per port, qualified by in_vld
//   in_rd_en   pop strobe per port (combinational)
//   out_data   registered beat data
//   out_last   registered end-of-packet
//   out_port   source port of the current beat
//   out_vld    output beat valid
//   out_rdy    downstream accept
//   busy       high while a grant is held
// ---------------------------------------------------------------------------
module ipml_fifo_rr_arbiter_v1_0 #(
    parameter  int N_PORT    = 4,
    parameter  int W         = 32,
    parameter  int PKT_MODE  = 1,
    parameter  int MAX_BURST = 16,
    localparam int PW        = (N_PORT > 1) ? $clog2(N_PORT) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_PORT*W-1:0] in_data,
    input  logic [N_PORT-1:0]   in_vld,
    input  logic [N_PORT-1:0]   in_last,
    output logic [N_PORT-1:0]   in_rd_en,
    output logic [W-1:0]        out_data,
    output logic                out_last,
    output logic [PW-1:0]       out_port,
    output logic                out_vld,
    input  logic                out_rdy,
    output logic                busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [PW-1:0]  r_gnt;
    logic [PW-1:0]  w_gnt_nxt;
    logic [PW-1:0]  r_ptr;
    logic [PW-1:0]  w_ptr_nxt;
    logic [7:0]     r_beat_cnt;
    logic [7:0]     w_beat_cnt_nxt;

    logic [W-1:0]   r_out_data;
    logic           r_out_last;
    logic [PW-1:0]  r_out_port;
    logic           r_out_vld;

    logic [W-1:0]   w_port_data [N_PORT];
    logic [PW-1:0]  w_scan;
    logic [PW-1:0]  w_cand;
    logic           w_slice_ok;
    logic           w_pop;

    always_comb begin
        for (int i = 0; i < N_PORT; i++) begin
            w_port_data[i] = in_data[i*W +: W];
        end
    end

    // Round-robin scan: walking k downwards lets the smallest offset from
    // ptr+1 win, so no early exit is needed.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_scan = '0;
        w_cand = '0;
        for (int k = N_PORT; k >= 1; k--) begin
            w_cand = PW'((int'(r_ptr) + k) % N_PORT);
            if (in_vld[w_cand]) begin
                w_scan = w_cand;
            end
        end
    end

    // The slice may be reloaded when it is empty or being drained this cycle.
    assign w_slice_ok = ~r_out_vld | out_rdy;
    assign w_pop      = (r_state == ST_LOCK) & in_vld[r_gnt] & w_slice_ok;

    // Only the granted port is ever popped; the reset of r_state keeps this
    // at zero while rst_n is low.
    always_comb begin
        in_rd_en = '0;
        if (w_pop) begin
            in_rd_en[r_gnt] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_nxt      = r_gnt;
        w_ptr_nxt      = r_ptr;
        w_beat_cnt_nxt = r_beat_cnt;
        case (r_state)
            ST_IDLE: begin
                if (|in_vld) begin
                    w_gnt_nxt      = w_scan;
                    w_beat_cnt_nxt = '0;
                    w_state_nxt    = ST_LOCK;
                end
            end
            ST_LOCK: begin
                if (PKT_MODE != 0) begin
                    // An empty source mid-packet simply waits; nothing else is served.
                    if (w_pop && in_last[r_gnt]) begin
                        w_ptr_nxt   = r_gnt;
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    if (w_pop) begin
                        w_beat_cnt_nxt = r_beat_cnt + 8'd1;
                    end
                    if (!in_vld[r_gnt] ||
                        (w_pop && (r_beat_cnt == 8'(MAX_BURST - 1)))) begin
                        w_ptr_nxt   = r_gnt;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_gnt      <= '0;
            r_ptr      <= PW'(N_PORT - 1);
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_ptr      <= w_ptr_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    // Output slice: loaded on every pop, emptied once accepted with no refill.
    // NOTE: the data registers are reset too, so outputs read as zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data <= '0;
            r_out_last <= 1'b0;
            r_out_port <= '0;
            r_out_vld  <= 1'b0;
        end else if (w_pop) begin
            r_out_data <= w_port_data[r_gnt];
            r_out_last <= in_last[r_gnt];
            r_out_port <= r_gnt;
            r_out_vld  <= 1'b1;
        end else if (w_slice_ok) begin
            r_out_vld  <= 1'b0;
        end
    end

    assign out_data = r_out_data;
    assign out_last = r_out_last;
    assign out_port = r_out_port;
    assign out_vld  = r_out_vld;
    assign busy     = (r_state == ST_LOCK);

endmodule
